lock_rr_arbiter: RTL and testbench
==================================

Name: lock_rr_arbiter

Overview:
Round-robin arbiter with lock semantics for one shared resource (bus port, memory bank, shared datapath) among N_REQ requesters.
- Once granted, a requester owns the resource until it releases it, drops its request, or exceeds a maximum hold time.
- Ownership then rotates so the next requester after the previous owner has highest priority.
- Sits between requester front-ends and the shared resource mux; `owner` drives the mux select directly.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_HOLD, 16, maximum cycles a grant may be held; 0 = unlimited
OWN_W, $clog2(N_REQ), width of owner index
CNT_W, 8, hold counter width; MAX_HOLD must be < 2**CNT_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
req  input  N_REQ  per-requester request level, held high while the resource is wanted
rel  input  N_REQ  per-requester release pulse; only the owner's bit is honoured
grant  output  N_REQ  registered one-hot grant, all-zero when free
busy  output  1  high while any grant is asserted
owner  output  OWN_W  index of current owner; holds the last owner when free
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (rst=0, asynchronous):
  - grant=0, busy=0, owner=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant drops the grant immediately, with no timeout pulse.
- The FSM has two states, IDLE and LOCKED. All outputs are registered.
- IDLE:
  - If req != 0 at a rising edge, select the first set bit scanning ptr, ptr+1, ... N_REQ-1, 0, ... (wrap).
  - That edge sets grant to the one-hot value, busy=1, owner=index, hold_cnt=0, state=LOCKED.
  - Latency: req seen at edge k gives grant visible after edge k (one cycle from req assertion).
  - If req == 0, remain IDLE with grant=0.
- LOCKED, evaluated each edge for the current owner o:
  - release if rel[o]=1, or req[o]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release: grant=0, busy=0, ptr=(o+1) mod N_REQ, state=IDLE, owner unchanged.
  - The release edge is the last edge grant was high. This guarantees exactly one free cycle between consecutive grants (turnaround for the resource mux).
  - timeout=1 for exactly the cycle following a MAX_HOLD-forced release, and only when rel[o]=0 and req[o]=1 at that edge. An explicit release coinciding with the limit does not pulse timeout.
  - Otherwise hold: grant unchanged, hold_cnt increments, saturating at 2**CNT_W-1 when MAX_HOLD=0.
- Ignored inputs:
  - rel bits of non-owners are ignored in all states.
  - rel in IDLE is ignored.
  - Requests arriving during LOCKED wait; they are never lost as long as req stays high.
- Fairness:
  - After owner o, requester o is lowest priority at the next arbitration.
  - With all N_REQ requesting continuously, grants cycle 0,1,2,...,N_REQ-1,0 with one free cycle between grants.
- Invariants:
  - grant is always one-hot or zero.
  - busy == |grant.
  - A requester whose req is low never receives grant.

Decomposition:
- Shared package lock_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCKED=1'b1;
  - default N_REQ and MAX_HOLD;
  - the OWN_W derivation function.
- One combinational sub-module, lock_rr_pick (inputs req, ptr; outputs found, idx, onehot), performs the rotated priority scan. Reuse it for any future N-way rotating arbiter.
- The FSM, counter and output registers stay in lock_rr_arbiter.

Test Plan:
- Reset mid-grant: req=4'b0010 held, after grant assert rst=0 -> grant=0, busy=0, owner=0, timeout=0 immediately. Release rst with req=0 -> stays IDLE.
- Single requester lock: req=4'b0100 from cycle 0, rel[2] pulsed at cycle 6 -> grant=4'b0100 visible cycles 1..6, grant=0 at cycle 7, ptr=3.
- Rotation with contention: req=4'b1111 constant, each owner pulses rel on its 2nd grant cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Timeout: MAX_HOLD=4, req=4'b0001 held high, no rel -> grant high exactly 4 cycles, then grant=0 with timeout=1 for one cycle. Re-grant to 0001 on the following cycle since it is the only requester.
- Request drop and foreign release: owner=1 with req=4'b0011; rel[0] pulsed -> no effect. Then req[1] drops -> grant=0 next edge, then grant=4'b0001.
- Simultaneous release and limit: MAX_HOLD=3, rel[o] asserted on the 3rd hold cycle -> release with timeout staying 0.

Source files
------------

// File: rtl/lock_arb_pkg.sv
// lock_arb_pkg: shared state encoding, defaults and owner-width helper for the lock arbiter
package lock_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 16;

  function automatic int own_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lock_rr_pick.sv
// lock_rr_pick: rotated priority scan, first set req bit at or after ptr (wrapping)
module lock_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  int best;

  // keep the requester with the smallest rotated distance from ptr
  always_comb begin
    best = N;
    idx  = '0;
    for (int j = 0; j < N; j++) begin
      if (req[j] && ((j + N - int'(ptr)) % N) < best) begin
        best = (j + N - int'(ptr)) % N;
        idx  = W'(j);
      end
    end
  end

  assign found  = |req;
  assign onehot = found ? N'(1) << idx : '0;

endmodule

// File: rtl/lock_rr_arbiter.sv
// lock_rr_arbiter: round-robin arbiter whose grant is held until release, request drop or hold limit
module lock_rr_arbiter
  import lock_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int OWN_W    = own_w(N_REQ),
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic [OWN_W-1:0] owner,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             found;
  logic [OWN_W-1:0] idx;
  logic [N_REQ-1:0] onehot;
  logic             limit, rel_o, req_o;

  lock_rr_pick #(
    .N(N_REQ),
    .W(OWN_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (idx),
    .onehot(onehot)
  );

  assign rel_o = rel[owner_q];
  assign req_o = req[owner_q];
  assign limit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1));

  // arbitrate when idle; while locked, release or keep counting the hold time
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (found) begin
        grant_d = onehot;
        busy_d  = 1'b1;
        owner_d = idx;
        cnt_d   = '0;
        state_d = ST_LOCKED;
      end
    end else if (rel_o || !req_o || limit) begin
      grant_d   = '0;
      busy_d    = 1'b0;
      ptr_d     = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
      state_d   = ST_IDLE;
      timeout_d = limit && !rel_o && req_o;
    end else begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lock_rr_arbiter.sv
// tb_lock_rr_arbiter: vector-table and scoreboard checks on an unlimited-hold and a short-hold arbiter
module tb_lock_rr_arbiter;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_a = '0, rel_a = '0, req_b = '0, rel_b = '0;
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b, timeout_a, timeout_b;
  logic [1:0] owner_a, owner_b;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step = 0;

  always #5 clk = ~clk;

  lock_rr_arbiter u_a (
    .clk(clk), .rst(rst), .req(req_a), .rel(rel_a),
    .grant(grant_a), .busy(busy_a), .owner(owner_a), .timeout(timeout_a)
  );

  lock_rr_arbiter #(.MAX_HOLD(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .rel(rel_b),
    .grant(grant_b), .busy(busy_b), .owner(owner_b), .timeout(timeout_b)
  );

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] rl, input logic [3:0] g,
                              input logic b, input logic [1:0] o, input logic t);
    vec_t v;
    v.req = rq; v.rel = rl; v.grant = g; v.busy = b; v.owner = o; v.timeout = t;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s grant_busy_owner_timeout got %b want %b", name, act, want);
    end
  endtask

  task automatic check_out(input bit sel);
    vec_t e;
    e = exp_q.pop_front();
    cmp($sformatf("%s_step%0d", sel ? "B" : "A", step),
        sel ? {grant_b, busy_b, owner_b, timeout_b} : {grant_a, busy_a, owner_a, timeout_a},
        {e.grant, e.busy, e.owner, e.timeout});
  endtask

  task automatic apply(input bit sel, input vec_t v);
    if (sel) begin req_b = v.req; rel_b = v.rel; end
    else begin req_a = v.req; rel_a = v.rel; end
    exp_q.push_back(v);
    step++;
    @(posedge clk);
    #1;
    check_out(sel);
  endtask

  initial begin
    tab_a.push_back(mk(4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
    for (int i = 0; i < 5; i++) tab_a.push_back(mk(4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
    tab_a.push_back(mk(4'b0100, 4'b0100, 4'b0000, 0, 2, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b1000, 1, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b1000, 1, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b1000, 4'b0000, 0, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b1111, 4'b0001, 1, 0, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0001, 1, 0, 0));
    tab_a.push_back(mk(4'b1111, 4'b0001, 4'b0000, 0, 0, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0010, 1, 1, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0010, 1, 1, 0));
    tab_a.push_back(mk(4'b1111, 4'b0010, 4'b0000, 0, 1, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0100, 1, 2, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0100, 1, 2, 0));
    tab_a.push_back(mk(4'b1111, 4'b0100, 4'b0000, 0, 2, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b1000, 1, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b1000, 1, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b1000, 4'b0000, 0, 3, 0));
    tab_a.push_back(mk(4'b1111, 4'b0000, 4'b0001, 1, 0, 0));
    tab_a.push_back(mk(4'b1111, 4'b0001, 4'b0000, 0, 0, 0));
    tab_a.push_back(mk(4'b0011, 4'b0000, 4'b0010, 1, 1, 0));
    tab_a.push_back(mk(4'b0011, 4'b0001, 4'b0010, 1, 1, 0));
    tab_a.push_back(mk(4'b0011, 4'b0000, 4'b0010, 1, 1, 0));
    tab_a.push_back(mk(4'b0001, 4'b0000, 4'b0000, 0, 1, 0));
    tab_a.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tab_a.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tab_a.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tab_b.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tab_b.push_back(mk(4'b0001, 4'b0000, 4'b0000, 0, 0, 1));
    tab_b.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tab_b.push_back(mk(4'b0001, 4'b0001, 4'b0000, 0, 0, 0));
    tab_b.push_back(mk(4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    tab_b.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0));
    tab_b.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_A", {grant_a, busy_a, owner_a, timeout_a}, 8'b0);
    cmp("reset_B", {grant_b, busy_b, owner_b, timeout_b}, 8'b0);
    #2 rst = 1'b1;

    apply(0, mk(4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    apply(0, mk(4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    #2 rst = 1'b0;
    #1;
    cmp("async_reset_mid_grant", {grant_a, busy_a, owner_a, timeout_a}, 8'b0);
    req_a = '0;
    #2 rst = 1'b1;
    apply(0, mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    apply(0, mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0));

    foreach (tab_a[i]) apply(0, tab_a[i]);
    foreach (tab_b[i]) apply(1, tab_b[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
